// File: rtl/encoder_decoder_mac_pkg.sv
// Shared widths and arithmetic helpers for the encoder/decoder MAC pipeline.
// Values are carried in 64-bit containers so one helper serves every parameterisation.
package encoder_decoder_mac_pkg;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } rs_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = int'(i) + 1;
        end
        return r;
    endfunction

    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // clog2(1) == 0, so the accumulator never gets narrower than the product
    function automatic int acc_w(input int a_w, input int b_w, input int vec_len);
        return prod_w(a_w, b_w) + clog2(vec_len);
    endfunction

    function automatic rs_t round_sat(input logic signed [63:0] sum, input int shift, input int out_w);
        rs_t                res;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = sum;
        if (shift > 0) r = (sum + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        res.value = r;
        res.sat   = 1'b0;
        if (r > hi) begin
            res.value = hi;
            res.sat   = 1'b1;
        end else if (r < lo) begin
            res.value = lo;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/encoder_decoder_mac_pipe_if.sv
// Operand stream in, dot-product result stream out; both valid/ready.
interface encoder_decoder_mac_pipe_if #(
    parameter int A_WIDTH   = 13,
    parameter int B_WIDTH   = 10,
    parameter int OUT_WIDTH = 25
);
    logic                        in_valid;
    logic                        in_ready;
    logic [A_WIDTH-1:0]          in_a;
    logic signed [B_WIDTH-1:0]   in_b;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_sat;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/encoder_decoder_mac_mul.sv
// Registered signed x signed/unsigned multiplier stage; no reset so it packs into a DSP block.
module encoder_decoder_mac_mul
    import encoder_decoder_mac_pkg::*;
#(
    parameter int A_WIDTH  = 13,
    parameter int A_SIGNED = 0,
    parameter int B_WIDTH  = 10,
    parameter int PROD_W   = prod_w(A_WIDTH, B_WIDTH)
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic [A_WIDTH-1:0]        a,
    input  logic signed [B_WIDTH-1:0] b,
    output logic signed [PROD_W-1:0]  p
);
    localparam int EA_W = (A_SIGNED != 0) ? A_WIDTH : A_WIDTH + 1;

    logic signed [EA_W-1:0]         ea;
    logic signed [EA_W+B_WIDTH-1:0] full;
    logic                           unused_msb;

    generate
        if (A_SIGNED != 0) begin : g_sgn
            assign ea = a;
        end else begin : g_uns
            assign ea = {1'b0, a};
        end
    endgenerate

    // The zero-extension bit never reaches the product's top bit, so truncation is exact
    assign full       = ea * b;
    assign unused_msb = full[EA_W+B_WIDTH-1];

    always_ff @(posedge clk) begin
        if (en) p <= full[PROD_W-1:0];
    end
endmodule

// File: rtl/encoder_decoder_mac_pipe.sv
// Three-stage MAC: operand register, registered multiply, accumulate/round/saturate.
// Any pending-but-unaccepted result freezes the whole pipeline.
module encoder_decoder_mac_pipe
    import encoder_decoder_mac_pkg::*;
#(
    parameter int A_WIDTH   = 13,
    parameter int A_SIGNED  = 0,
    parameter int B_WIDTH   = 10,
    parameter int VEC_LEN   = 4,
    parameter int SHIFT     = 0,
    parameter int OUT_WIDTH = 25
) (
    input logic                       clk,
    input logic                       reset,
    input logic                       clear,
    encoder_decoder_mac_pipe_if.slave bus
);
    localparam int PROD_W = prod_w(A_WIDTH, B_WIDTH);
    localparam int ACC_W  = acc_w(A_WIDTH, B_WIDTH, VEC_LEN);
    localparam int CNT_W  = (clog2(VEC_LEN) > 0) ? clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

    logic                        stall;
    logic                        accept;
    logic [CNT_W-1:0]            cnt;
    logic                        s1_valid;
    logic                        s1_last;
    logic [A_WIDTH-1:0]          s1_a;
    logic signed [B_WIDTH-1:0]   s1_b;
    logic                        s2_valid;
    logic                        s2_last;
    logic signed [PROD_W-1:0]    s2_prod;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     prod_x;
    logic signed [ACC_W-1:0]     sum;
    rs_t                         rs;
    logic                        unused_rs;
    logic                        out_valid_q;
    logic signed [OUT_WIDTH-1:0] out_data_q;
    logic                        out_sat_q;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~reset & ~stall & ~clear;
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else if (clear) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (accept) begin
                s1_last <= (cnt == CNT_LAST);
                cnt     <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!stall && accept) begin
            s1_a <= bus.in_a;
            s1_b <= bus.in_b;
        end
    end

    encoder_decoder_mac_mul #(
        .A_WIDTH (A_WIDTH),
        .A_SIGNED(A_SIGNED),
        .B_WIDTH (B_WIDTH),
        .PROD_W  (PROD_W)
    ) u_mul (
        .clk(clk),
        .en (~stall),
        .a  (s1_a),
        .b  (s1_b),
        .p  (s2_prod)
    );

    // Accumulator idles at zero between vectors, so "first element loads prod" is just acc + prod
    assign prod_x    = ACC_W'(s2_prod);
    assign sum       = acc + prod_x;
    assign unused_rs = ^rs.value;

    always_comb begin
        rs = round_sat(64'(sum), SHIFT, OUT_WIDTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (!stall && s2_valid) begin
                acc <= s2_last ? '0 : sum;
            end
            if (!stall) begin
                if (s2_valid && s2_last && !clear) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= rs.value[OUT_WIDTH-1:0];
                    out_sat_q   <= rs.sat;
                end else if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end
endmodule
